// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: exception/interrupt vectors, NOP, reset PC.
// The vectors depend on IF_KERNEL_BIT_EN, which makes PC[31] the kernel-mode bit.
package mips_pkg;

`ifdef IF_KERNEL_BIT_EN
  localparam logic        KERNEL_BIT_EN = 1'b1;
  localparam logic [31:0] IRQ_VEC       = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC       = 32'h8000_0008;
`else
  localparam logic        KERNEL_BIT_EN = 1'b0;
  localparam logic [31:0] IRQ_VEC       = 32'h0000_0004;
  localparam logic [31:0] EXC_VEC       = 32'h0000_0008;
`endif

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Word-align an address and drop the kernel bit when it does not exist.
  function automatic logic [31:0] pc_legal(input logic [31:0] a);
    logic [31:0] r;
    r = {a[31:2], 2'b00};
    if (!KERNEL_BIT_EN) r[31] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, bubble insertion, hold and normal load.
// Bubble has priority over hold so a redirect always squashes the fetched slot.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        irq_mark,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        id_irq
);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      id_irq      <= 1'b0;
    end else if (bubble) begin
      id_instr    <= NOP;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b0;
      id_irq      <= irq_mark;
    end else if (!hold) begin
      id_instr    <= instr;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
      id_irq      <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, prioritised next-PC selection, interrupt
// edge latch and IF/ID register. Optional kernel bit via IF_KERNEL_BIT_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_jump,
  input  logic [25:0] id_jump_index,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,
  input  logic        exc,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        id_irq
);

`ifdef IF_KERNEL_BIT_EN
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
`else
  localparam logic [31:0] PC_INIT = '0;
`endif

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        irq_q;
  logic        irq_pending;
  logic        irq_edge;
  logic        irq_masked;
  logic        redirect;
  logic        take;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign irq_edge  = irq & ~irq_q;
  assign redirect  = exc | ex_branch_taken | id_jr | id_jump;

`ifdef IF_KERNEL_BIT_EN
  assign irq_masked = pc[31];
`else
  assign irq_masked = 1'b0;
`endif

  assign take = irq_pending & ~redirect & ~stall & ~irq_masked;

  always_comb begin
    pc_next = pc_plus4;
    if (exc)                  pc_next = EXC_VEC;
    else if (ex_branch_taken) pc_next = ex_branch_target;
    else if (id_jr)           pc_next = id_jr_target;
    else if (id_jump)         pc_next = {pc[31:28], id_jump_index, 2'b00};
    else if (take)            pc_next = IRQ_VEC;
    pc_next = pc_legal(pc_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_INIT;
    end else if (redirect || take || !stall) begin
      pc <= pc_next;
    end
  end

  // A fresh edge in the take cycle re-arms pending instead of being lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_q <= irq;
      if (irq_edge)  irq_pending <= 1'b1;
      else if (take) irq_pending <= 1'b0;
    end
  end

  // On an interrupt take the squashed instruction's address is the return address.
  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .hold        (stall),
    .bubble      (redirect | take),
    .instr       (imem_instr),
    .pc_plus4    (take ? pc : pc_plus4),
    .irq_mark    (take),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .id_irq      (id_irq)
  );

endmodule
